// File: rtl/state_metric_array.sv
// Add-compare-select state metric array for a rate-1/2 Viterbi decoder: one trellis
// step per valid branch-metric set, with modulo normalisation and best-state tracking.
module state_metric_array #(
   parameter int K         = 4,
   parameter int G0        = 13,
   parameter int G1        = 15,
   parameter int BM_W      = 4,
   parameter int SM_W      = 8,
   parameter int INIT_BIAS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  frame_start,
   input  logic                  bm_valid,
   input  logic [4*BM_W-1:0]     branch_metric,
   output logic [(1<<(K-1))-1:0] decision,
   output logic                  dec_valid,
   output logic [K-2:0]          best_state,
   output logic [SM_W-1:0]       best_metric,
   output logic                  norm_event
);
   localparam int N   = 1 << (K - 1);
   localparam int S_W = K - 1;
   localparam logic [K-1:0]    G0_V   = G0[K-1:0];
   localparam logic [K-1:0]    G1_V   = G1[K-1:0];
   localparam logic [SM_W-1:0] BIAS_V = INIT_BIAS[SM_W-1:0];

   typedef logic [N-1:0][SM_W-1:0] sm_vec_t;

   function automatic logic parity_k(input logic [K-1:0] v);
      return ^v;
   endfunction

   function automatic logic [1:0] code_idx(input logic [K-1:0] r);
      return {parity_k(r & G0_V), parity_k(r & G1_V)};
   endfunction

   function automatic sm_vec_t init_metrics();
      sm_vec_t v;
      for (int j = 0; j < N; j++) begin
         v[j] = (j == 0) ? {SM_W{1'b0}} : BIAS_V;
      end
      return v;
   endfunction

   localparam sm_vec_t INIT_V = init_metrics();

   if (K < 3 || K > 7) begin : g_bad_k
      $error("state_metric_array: K=%0d outside 3..7", K);
   end
   if (G0 == 0 || G1 == 0) begin : g_bad_gen
      $error("state_metric_array: generator polynomial is zero");
   end
   if ((K - 1) * ((1 << BM_W) - 1) >= (1 << (SM_W - 2))) begin : g_bad_bm
      $error("state_metric_array: SM_W too narrow for BM_W and K");
   end
   if (INIT_BIAS >= (1 << (SM_W - 2))) begin : g_bad_bias
      $error("state_metric_array: INIT_BIAS too large for SM_W");
   end

   logic                 step_s;
   sm_vec_t              sm_r;
   sm_vec_t              src_s;
   sm_vec_t              acs_s;
   sm_vec_t              new_s;
   logic [3:0][SM_W-1:0] bm_ext_s;
   logic [N-1:0]         dec_s;
   logic [N-1:0]         msb_s;
   logic                 norm_s;
   logic [S_W-1:0]       best_idx_s;
   logic [SM_W-1:0]      best_val_s;

   assign step_s = enable & bm_valid;
   assign src_s  = frame_start ? INIT_V : sm_r;
   assign norm_s = &msb_s;

   for (genvar i = 0; i < 4; i++) begin : g_bm
      assign bm_ext_s[i] = SM_W'(branch_metric[i*BM_W +: BM_W]);
   end

   // Predecessor indices and branch codes are fixed by the trellis, so they fold to constants.
   for (genvar j = 0; j < N; j++) begin : g_acs
      localparam int P0   = 2 * (j % (N / 2));
      localparam int P1   = P0 + 1;
      localparam int B    = j >> (K - 2);
      localparam int R0_I = (B << (K - 1)) | P0;
      localparam int R1_I = (B << (K - 1)) | P1;
      localparam logic [1:0] IDX0 = code_idx(R0_I[K-1:0]);
      localparam logic [1:0] IDX1 = code_idx(R1_I[K-1:0]);

      logic [SM_W-1:0] cand0_s;
      logic [SM_W-1:0] cand1_s;

      assign cand0_s  = src_s[P0] + bm_ext_s[IDX0];
      assign cand1_s  = src_s[P1] + bm_ext_s[IDX1];
      assign dec_s[j] = (cand1_s < cand0_s);
      assign acs_s[j] = dec_s[j] ? cand1_s : cand0_s;
      assign msb_s[j] = acs_s[j][SM_W-1];
      assign new_s[j] = norm_s ? {1'b0, acs_s[j][SM_W-2:0]} : acs_s[j];
   end

   // Minimum search over the normalised metrics; strict compare keeps the lowest index on ties.
   always_comb begin
      best_val_s = new_s[0];
      best_idx_s = {S_W{1'b0}};
      for (int j = 1; j < N; j++) begin
         if (new_s[j] < best_val_s) begin
            best_val_s = new_s[j];
            best_idx_s = S_W'(j);
         end else begin
            best_val_s = best_val_s;
            best_idx_s = best_idx_s;
         end
      end
   end

   // Metric storage and registered step outputs; everything except dec_valid holds between steps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sm_r        <= INIT_V;
         decision    <= {N{1'b0}};
         dec_valid   <= 1'b0;
         best_state  <= {S_W{1'b0}};
         best_metric <= {SM_W{1'b0}};
         norm_event  <= 1'b0;
      end else begin
         dec_valid <= step_s;
         if (step_s) begin
            sm_r        <= new_s;
            decision    <= dec_s;
            best_state  <= best_idx_s;
            best_metric <= best_val_s;
            norm_event  <= norm_s;
         end
      end
   end

endmodule

// File: tb/tb_state_metric_array.sv
// Scoreboard bench for state_metric_array: default build (a) plus an INIT_BIAS=0 build (b)
// used for the normalisation run. Expected results are hand-derived from the trellis.
module tb_state_metric_array;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        frame_start;
   logic        bm_valid;
   logic [15:0] branch_metric;
   logic [7:0]  decision_a;
   logic        dec_valid_a;
   logic [2:0]  best_state_a;
   logic [7:0]  best_metric_a;
   logic        norm_event_a;

   logic        b_bm_valid;
   logic [15:0] b_branch_metric;
   logic [7:0]  decision_b;
   logic        dec_valid_b;
   logic [2:0]  best_state_b;
   logic [7:0]  best_metric_b;
   logic        norm_event_b;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      string      tag;
      logic [7:0] dec;
      logic [2:0] bs;
      logic [7:0] bm;
      logic       nrm;
      logic       chk;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea;
   exp_t eb;

   always #5 clk = ~clk;

   state_metric_array dut_a (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
      .bm_valid(bm_valid), .branch_metric(branch_metric),
      .decision(decision_a), .dec_valid(dec_valid_a), .best_state(best_state_a),
      .best_metric(best_metric_a), .norm_event(norm_event_a)
   );

   state_metric_array #(.INIT_BIAS(0)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .frame_start(frame_start),
      .bm_valid(b_bm_valid), .branch_metric(b_branch_metric),
      .decision(decision_b), .dec_valid(dec_valid_b), .best_state(best_state_b),
      .best_metric(best_metric_b), .norm_event(norm_event_b)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic cmp_vec(input string who, input exp_t e, input logic [7:0] d,
                          input logic [2:0] s, input logic [7:0] m, input logic n);
      vectors++;
      if ({d, s, m, n} !== {e.dec, e.bs, e.bm, e.nrm}) begin
         miscompares++;
         $display("FAIL %s_%s got dec=%h state=%0d metric=%0d norm=%0b expected dec=%h state=%0d metric=%0d norm=%0b",
                  who, e.tag, d, s, m, n, e.dec, e.bs, e.bm, e.nrm);
      end
   endtask

   // Monitors: pop one expectation per dec_valid cycle, sampled on the falling edge.
   always @(negedge clk) begin
      if (dec_valid_a) begin
         if (qa.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL a_unexpected_dec_valid got dec_valid=1 expected 0");
         end else begin
            ea = qa.pop_front();
            if (ea.chk) cmp_vec("a", ea, decision_a, best_state_a, best_metric_a, norm_event_a);
         end
      end
   end

   always @(negedge clk) begin
      if (dec_valid_b) begin
         if (qb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL b_unexpected_dec_valid got dec_valid=1 expected 0");
         end else begin
            eb = qb.pop_front();
            if (eb.chk) cmp_vec("b", eb, decision_b, best_state_b, best_metric_b, norm_event_b);
         end
      end
   end

   task automatic step_a(input string tag, input logic [3:0] m0, input logic [3:0] m1,
                         input logic [3:0] m2, input logic [3:0] m3, input logic fs,
                         input logic chk, input logic [7:0] dec, input logic [2:0] bs,
                         input logic [7:0] bm, input logic nrm);
      exp_t e;
      e.tag = tag; e.dec = dec; e.bs = bs; e.bm = bm; e.nrm = nrm; e.chk = chk;
      qa.push_back(e);
      branch_metric = {m3, m2, m1, m0};
      frame_start   = fs;
      bm_valid      = 1'b1;
      @(posedge clk);
      #1;
      bm_valid    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic step_b(input string tag, input logic [7:0] bm, input logic nrm);
      exp_t e;
      e.tag = tag; e.dec = 8'h00; e.bs = 3'd0; e.bm = bm; e.nrm = nrm; e.chk = 1'b1;
      qb.push_back(e);
      b_branch_metric = {4{4'd15}};
      b_bm_valid      = 1'b1;
      @(posedge clk);
      #1;
      b_bm_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_decision"},    {24'd0, decision_a},    32'd0);
      check({tag, "_dec_valid"},   {31'd0, dec_valid_a},   32'd0);
      check({tag, "_best_state"},  {29'd0, best_state_a},  32'd0);
      check({tag, "_best_metric"}, {24'd0, best_metric_a}, 32'd0);
      check({tag, "_norm_event"},  {31'd0, norm_event_a},  32'd0);
   endtask

   logic [3:0] r [4];

   initial begin
      rst             = 1'b1;
      enable          = 1'b0;
      frame_start     = 1'b0;
      bm_valid        = 1'b0;
      branch_metric   = 16'h0000;
      b_bm_valid      = 1'b0;
      b_branch_metric = 16'h0000;

      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("in_reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("after_release");
      enable = 1'b1;

      // First step from initial metrics, then a single-cycle dec_valid pulse.
      step_a("first_zero_bm", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h00, 3'd0, 8'd0, 1'b0);
      @(posedge clk);
      #1;
      check("single_pulse_dec_valid", {31'd0, dec_valid_a}, 32'd0);

      // Back-to-back steps through a hand-traced trellis.
      step_a("mixed_bm",     4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b1, 8'h28, 3'd0, 8'd1, 1'b0);
      step_a("best_nonzero", 4'd9, 4'd0, 4'd2, 4'd7, 1'b0, 1'b1, 8'h00, 3'd7, 8'd1, 1'b0);
      step_a("tie_lowest",   4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'hFF, 3'd3, 8'd1, 1'b0);

      // Enable low for three cycles with bm_valid held high: nothing may move.
      enable        = 1'b0;
      bm_valid      = 1'b1;
      branch_metric = {4{4'd5}};
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("hold_dec_valid",   {31'd0, dec_valid_a},   32'd0);
         check("hold_best_state",  {29'd0, best_state_a},  32'd3);
         check("hold_best_metric", {24'd0, best_metric_a}, 32'd1);
      end
      enable = 1'b1;
      step_a("after_hold", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'hFF, 3'd1, 8'd1, 1'b0);

      // Random history, then frame_start must restore the initial metrics.
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < 4; i++) r[i] = 4'($urandom_range(0, 15));
         step_a("random", r[0], r[1], r[2], r[3], 1'b0, 1'b0, 8'h00, 3'd0, 8'd0, 1'b0);
      end
      step_a("frame_start_zero", 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 8'h00, 3'd0, 8'd0, 1'b0);
      step_a("frame_start_mixed", 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b1, 8'h2C, 3'd0, 8'd1, 1'b0);

      // Reset mid-stream with a step in flight.
      bm_valid      = 1'b1;
      branch_metric = {4{4'd5}};
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_idle_outputs("mid_reset");
      @(posedge clk);
      #1;
      check("mid_reset_discard", {31'd0, dec_valid_a}, 32'd0);
      bm_valid = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_no_pulse", {31'd0, dec_valid_a}, 32'd0);
      step_a("post_reset_first", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 8'h00, 3'd0, 8'd0, 1'b0);

      // Normalisation run on the zero-bias build: equal metrics climb by 15 per step.
      for (int s = 1; s <= 8; s++) begin
         step_b("climb", 8'(15 * s), 1'b0);
      end
      step_b("normalise", 8'd7, 1'b1);
      step_b("after_norm", 8'd22, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("a_queue_drained", qa.size(), 32'd0);
      check("b_queue_drained", qb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
